// File: rtl/fib_pkg.sv
// Shared types for the programmable second-order sequence generator.
// Imported by the top and by the bench-facing interface users.
package fib_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_STOP = 1'b1
  } mode_e;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Output stream port of fib_seq_gen: one term plus its index
// under a valid/ready handshake.
interface fib_seq_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]  out_index;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    output out_ready
  );

endinterface

// File: rtl/fib_step.sv
// One recurrence step: sum of two terms, with overflow propagated
// from either operand or from the carry out of the add.
module fib_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  a_ovf_i,
  input  logic                  b_ovf_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  ovf_o
);

  logic carry;

  assign {carry, sum_o} = {1'b0, a_i} + {1'b0, b_i};
  assign ovf_o = carry | a_ovf_i | b_ovf_i;

endmodule

// File: rtl/fib_seq_gen.sv
// Seeded T(n)=T(n-1)+T(n-2) stream source with term limit,
// free-run, and wrap/stop overflow handling.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] seed0,
  input  logic [DATA_WIDTH-1:0] seed1,
  input  logic [CNT_WIDTH-1:0]  num_terms,
  fib_seq_gen_if.master         strm,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] nxt_q, nxt_d;
  logic                  cur_ovf_q, cur_ovf_d;
  logic                  nxt_ovf_q, nxt_ovf_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] sum;
  logic                  sum_ovf;
  logic                  fire;
  logic                  end_cnt;
  logic                  end_ovf;
  logic                  adv;

  fib_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .a_i     (cur_q),
    .b_i     (nxt_q),
    .a_ovf_i (cur_ovf_q),
    .b_ovf_i (nxt_ovf_q),
    .sum_o   (sum),
    .ovf_o   (sum_ovf)
  );

  assign fire    = (state_q == RUN) & strm.out_ready;
  assign end_cnt = (num_q != '0) &&
                   (idx_q == num_q - 1'b1);
  assign end_ovf = (mode_q == MODE_STOP) & nxt_ovf_q;
  // Normal termination holds the last emitted term on the outputs.
  assign adv     = fire & (abort | ~(end_cnt | end_ovf));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    cur_ovf_d = cur_ovf_q;
    nxt_ovf_d = nxt_ovf_q;
    num_d     = num_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = RUN;
          mode_d    = mode_e'(mode);
          num_d     = num_terms;
          cur_d     = seed0;
          nxt_d     = seed1;
          cur_ovf_d = 1'b0;
          nxt_ovf_d = 1'b0;
          idx_d     = '0;
          ovf_d     = 1'b0;
        end
      end
      RUN: begin
        if (adv) begin
          cur_d     = nxt_q;
          cur_ovf_d = nxt_ovf_q;
          nxt_d     = sum;
          nxt_ovf_d = sum_ovf;
          idx_d     = idx_q + 1'b1;
        end
        if (abort) begin
          state_d = IDLE;
        end else if (fire) begin
          if (end_cnt) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (end_ovf) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ovf_d   = 1'b1;
          end else begin
            ovf_d = ovf_q | nxt_ovf_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      mode_q    <= MODE_WRAP;
      cur_q     <= '0;
      nxt_q     <= '0;
      cur_ovf_q <= 1'b0;
      nxt_ovf_q <= 1'b0;
      num_q     <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      cur_ovf_q <= cur_ovf_d;
      nxt_ovf_q <= nxt_ovf_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign strm.out_valid = (state_q == RUN);
  assign strm.out_data  = cur_q;
  assign strm.out_index = idx_q;
  assign busy           = (state_q == RUN);
  assign done           = done_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen at DATA_WIDTH=8: expected terms
// come from an unbounded-integer model of the recurrence.
module tb_fib_seq_gen;

  localparam int DW = 8;
  localparam int CW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] idx;
    logic          ovf;
  } item_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] seed0 = '0;
  logic [DW-1:0] seed1 = '0;
  logic [CW-1:0] num_terms = '0;
  logic          busy;
  logic          done;
  logic          overflow;

  item_t sb[$];
  int    tests = 0;
  int    fails = 0;
  int    done_cnt;

  fib_seq_gen_if #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) u_if ();

  fib_seq_gen #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .seed0     (seed0),
    .seed1     (seed1),
    .num_terms (num_terms),
    .strm      (u_if),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // True-valued recurrence; a term overflowed if it exceeds 255.
  task automatic model(input longint s0, input longint s1,
                       input int n, input bit stop,
                       input int cap);
    longint a;
    longint b;
    longint t;
    bit     sticky;
    int     lim;
    item_t  it;
    a = s0;
    b = s1;
    sticky = 1'b0;
    lim = (n != 0) ? n : cap;
    for (int i = 0; i < lim; i++) begin
      if (stop && a > 255) break;
      sticky = sticky | (a > 255);
      it.data = a[7:0];
      it.idx  = i[15:0];
      it.ovf  = sticky;
      sb.push_back(it);
      t = a + b;
      a = b;
      b = t;
    end
  endtask

  task automatic do_start(input logic [DW-1:0] s0,
                          input logic [DW-1:0] s1,
                          input logic [CW-1:0] n,
                          input logic m);
    seed0 = s0;
    seed1 = s1;
    num_terms = n;
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int max_cyc, input bit rnd);
    item_t         e;
    logic [DW-1:0] hd;
    logic [CW-1:0] hi;
    bit            stalled;
    stalled = 1'b0;
    hd = '0;
    hi = '0;
    done_cnt = 0;
    for (int c = 0; c < max_cyc && sb.size() > 0; c++) begin
      u_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) done_cnt++;
      if (u_if.out_valid) begin
        if (stalled) begin
          tests++;
          if (u_if.out_data !== hd || u_if.out_index !== hi) begin
            fails++;
            $display("FAIL stall_hold got %0d@%0d want %0d@%0d",
                     u_if.out_data, u_if.out_index, hd, hi);
          end
        end
        if (u_if.out_ready) begin
          e = sb.pop_front();
          tests++;
          if (u_if.out_data !== e.data ||
              u_if.out_index !== e.idx ||
              overflow !== e.ovf) begin
            fails++;
            $display("FAIL term got d=%0d i=%0d o=%0b want d=%0d i=%0d o=%0b",
                     u_if.out_data, u_if.out_index, overflow,
                     e.data, e.idx, e.ovf);
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = u_if.out_data;
          hi = u_if.out_index;
        end
      end
      tick();
    end
    u_if.out_ready = 1'b0;
    tests++;
    if (sb.size() != 0 || done_cnt != 0) begin
      fails++;
      $display("FAIL drain left=%0d early_done=%0d want 0 0",
               sb.size(), done_cnt);
      sb.delete();
    end
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if ({u_if.out_valid, busy, done, overflow} !== 4'b0 ||
        u_if.out_data !== '0 || u_if.out_index !== '0) begin
      fails++;
      $display("FAIL reset v/b/d/o=%b data=%0d idx=%0d want 0",
               {u_if.out_valid, busy, done, overflow},
               u_if.out_data, u_if.out_index);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    model(1, 1, 8, 1'b0, 0);
    do_start(8'd1, 8'd1, 16'd8, 1'b0);
    tests++;
    if (u_if.out_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL latency valid=%b busy=%b want 1 1",
               u_if.out_valid, busy);
    end
    drain(50, 1'b0);
    tests++;
    if ({done, busy, u_if.out_valid, overflow} !== 4'b1000) begin
      fails++;
      $display("FAIL basic_end d/b/v/o=%b want 1000",
               {done, busy, u_if.out_valid, overflow});
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_backpressure;
    model(1, 1, 8, 1'b0, 0);
    do_start(8'd1, 8'd1, 16'd8, 1'b0);
    drain(400, 1'b1);
    tests++;
    if (done !== 1'b1 || u_if.out_data !== 8'd21 ||
        u_if.out_index !== 16'd7) begin
      fails++;
      $display("FAIL bp_end done=%b data=%0d idx=%0d want 1 21 7",
               done, u_if.out_data, u_if.out_index);
    end
    tick();
  endtask

  task automatic test_stop;
    model(1, 1, 0, 1'b1, 64);
    do_start(8'd1, 8'd1, 16'd0, 1'b1);
    drain(100, 1'b0);
    tests++;
    if ({done, overflow, busy} !== 3'b110 ||
        u_if.out_data !== 8'd233 ||
        u_if.out_index !== 16'd12) begin
      fails++;
      $display("FAIL stop_end d/o/b=%b data=%0d idx=%0d want 110 233 12",
               {done, overflow, busy},
               u_if.out_data, u_if.out_index);
    end
    tick();
  endtask

  task automatic test_lucas;
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky got %b want 1", overflow);
    end
    model(2, 1, 1, 1'b0, 0);
    do_start(8'd2, 8'd1, 16'd1, 1'b0);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear got %b want 0", overflow);
    end
    drain(20, 1'b0);
    tests++;
    if (done !== 1'b1 || u_if.out_data !== 8'd2) begin
      fails++;
      $display("FAIL lucas1 done=%b data=%0d want 1 2",
               done, u_if.out_data);
    end
    tick();
    model(2, 1, 3, 1'b0, 0);
    do_start(8'd2, 8'd1, 16'd3, 1'b0);
    drain(20, 1'b0);
    tests++;
    if (done !== 1'b1 || u_if.out_data !== 8'd3) begin
      fails++;
      $display("FAIL lucas3 done=%b data=%0d want 1 3",
               done, u_if.out_data);
    end
    tick();
  endtask

  task automatic test_wrap;
    model(1, 1, 0, 1'b0, 16);
    do_start(8'd1, 8'd1, 16'd0, 1'b0);
    drain(100, 1'b0);
    tests++;
    if (busy !== 1'b1 || u_if.out_valid !== 1'b1 ||
        u_if.out_index !== 16'd16) begin
      fails++;
      $display("FAIL wrap_cont busy=%b valid=%b idx=%0d want 1 1 16",
               busy, u_if.out_valid, u_if.out_index);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({u_if.out_valid, done, overflow} !== 3'b001) begin
      fails++;
      $display("FAIL wrap_abort v/d/o=%b want 001",
               {u_if.out_valid, done, overflow});
    end
  endtask

  task automatic test_abort;
    model(1, 1, 0, 1'b0, 4);
    do_start(8'd1, 8'd1, 16'd0, 1'b0);
    drain(50, 1'b0);
    tick();
    tests++;
    if (u_if.out_index !== 16'd4 || u_if.out_data !== 8'd5) begin
      fails++;
      $display("FAIL stall4 data=%0d idx=%0d want 5 4",
               u_if.out_data, u_if.out_index);
    end
    start = 1'b1;
    tick();
    tests++;
    if (u_if.out_index !== 16'd4 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_in_run idx=%0d busy=%b want 4 1",
               u_if.out_index, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    tests++;
    if ({u_if.out_valid, done, busy} !== 3'b000) begin
      fails++;
      $display("FAIL abort v/d/b=%b want 000",
               {u_if.out_valid, done, busy});
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_after done=%b busy=%b want 0 0",
               done, busy);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || u_if.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL start_abort busy=%b valid=%b want 0 0",
               busy, u_if.out_valid);
    end
  endtask

  task automatic test_reset_midrun;
    do_start(8'd1, 8'd1, 16'd0, 1'b0);
    u_if.out_ready = 1'b1;
    repeat (15) tick();
    u_if.out_ready = 1'b0;
    tests++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset ovf=%b busy=%b want 1 1",
               overflow, busy);
    end
    #2;
    resetn = 1'b0;
    #1;
    tests++;
    if ({u_if.out_valid, busy, done, overflow} !== 4'b0 ||
        u_if.out_data !== '0 || u_if.out_index !== '0) begin
      fails++;
      $display("FAIL async_reset v/b/d/o=%b data=%0d idx=%0d want 0",
               {u_if.out_valid, busy, done, overflow},
               u_if.out_data, u_if.out_index);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    tests++;
    if (u_if.out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset valid=%b busy=%b want 0 0",
               u_if.out_valid, busy);
    end
  endtask

  initial begin
    u_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stop();
    test_lucas();
    test_wrap();
    test_abort();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
